// File: rtl/fft_stage_sequencer.sv
// Frame sequencer for a multi-stage FFT datapath: loads a frame, walks the
// stage enables one at a time, then holds the result until it is consumed.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// LOAD  | one-cycle load_en strobe capturing the input samples
// STAGE | stage k enabled, c counts cycles within the stage
// HOLD  | result valid; waits for out_ready
module fft_stage_sequencer #(
    parameter int STAGE_CYCLES = 5,
    parameter int N_STAGES     = 4
) (
    input  logic       clk_100,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic       load_en,
    output logic [3:0] enable,
    output logic [1:0] SEL,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STAGE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] C_LAST = 4'(STAGE_CYCLES - 1);
    localparam logic [1:0] K_LAST = 2'(N_STAGES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] k;
    logic [3:0] c;
    logic       stage_done;

    assign stage_done = (c == C_LAST);

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state     <= IDLE;
            k         <= 2'd0;
            c         <= 4'd0;
            frame_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == HOLD && out_ready && !abort) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            // Counters only advance while staying in STAGE; any entry starts at k=0, c=0.
            if (state == STAGE && state_nxt == STAGE) begin
                if (stage_done) begin
                    c <= 4'd0;
                    k <= k + 2'd1;
                end else begin
                    c <= c + 4'd1;
                end
            end else begin
                c <= 4'd0;
                k <= 2'd0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = LOAD;
                LOAD:    state_nxt = STAGE;
                STAGE:   if (stage_done && k == K_LAST) state_nxt = HOLD;
                HOLD:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        load_en   = 1'b0;
        enable    = 4'd0;
        SEL       = 2'd0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            LOAD:  load_en = 1'b1;
            STAGE: begin
                enable = 4'b0001 << k;
                SEL    = k;
            end
            HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fft_stage_sequencer;

    localparam int SC  = 5;
    localparam int NS  = 4;
    localparam int LAT = 2 + NS * SC;

    logic       clk_100 = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, load_en, out_valid, busy;
    logic [3:0] enable;
    logic [1:0] SEL;
    logic [7:0] frame_cnt;

    logic       b_in_valid = 1'b0;
    logic       b_out_ready = 1'b0;
    logic       b_abort = 1'b0;
    logic       b_in_ready, b_load_en, b_out_valid, b_busy;
    logic [3:0] b_enable;
    logic [1:0] b_SEL;
    logic [7:0] b_frame_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk_100 = ~clk_100;

    fft_stage_sequencer #(.STAGE_CYCLES(SC), .N_STAGES(NS)) dut (
        .clk_100(clk_100), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .abort(abort), .load_en(load_en), .enable(enable), .SEL(SEL),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_cnt(frame_cnt)
    );

    fft_stage_sequencer #(.STAGE_CYCLES(1), .N_STAGES(1)) dut_b (
        .clk_100(clk_100), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .abort(b_abort), .load_en(b_load_en), .enable(b_enable), .SEL(b_SEL),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy), .frame_cnt(b_frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a timeline measured from its accept cycle.
    bit m_active = 1'b0;
    int m_start  = 0;
    int m_fcnt   = 0;
    int m_cyc    = 0;
    bit chk_on   = 1'b0;

    always @(posedge clk_100) begin
        int d;
        d = m_cyc - m_start;
        if (reset) begin
            m_active = 1'b0;
            m_fcnt   = 0;
        end else if (abort) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1'b1;
                m_start  = m_cyc;
            end
        end else if (d >= LAT && out_ready) begin
            m_active = 1'b0;
            m_fcnt   = (m_fcnt + 1) % 256;
        end
        m_cyc++;
    end

    always @(negedge clk_100) begin
        int  d;
        bit  in_stage;
        int  e_en;
        int  e_sel;
        if (chk_on) begin
            d        = m_cyc - m_start;
            in_stage = m_active && d >= 2 && d < LAT;
            e_sel    = in_stage ? (d - 2) / SC : 0;
            e_en     = in_stage ? (1 << e_sel) : 0;
            chk("m_load_en",   32'(load_en),   32'(m_active && d == 1));
            chk("m_enable",    32'(enable),    32'(e_en));
            chk("m_sel",       32'(SEL),       32'(e_sel));
            chk("m_out_valid", 32'(out_valid), 32'(m_active && d >= LAT));
            chk("m_busy",      32'(busy),      32'(m_active));
            chk("m_in_ready",  32'(in_ready),  32'(!m_active));
            chk("m_frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        end
    end

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    initial begin
        int stage_en [4];
        stage_en = '{1, 2, 4, 8};

        tick();
        tick();
        reset = 1'b0;
        chk_on = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_frame_cnt", 32'(frame_cnt), 0);
        chk("reset_enable", 32'(enable), 0);

        // Minimal configuration: one stage of one cycle.
        b_in_valid = 1'b1;
        b_out_ready = 1'b1;
        tick();
        b_in_valid = 1'b0;
        chk("b_load", 32'(b_load_en), 1);
        chk("b_en_c1", 32'(b_enable), 0);
        tick();
        chk("b_en_c2", 32'(b_enable), 1);
        chk("b_sel_c2", 32'(b_SEL), 0);
        chk("b_ov_c2", 32'(b_out_valid), 0);
        tick();
        chk("b_en_c3", 32'(b_enable), 0);
        chk("b_ov_c3", 32'(b_out_valid), 1);
        tick();
        chk("b_fcnt_c4", 32'(b_frame_cnt), 1);
        chk("b_busy_c4", 32'(b_busy), 0);
        chk("b_in_ready_c4", 32'(b_in_ready), 1);
        b_out_ready = 1'b0;

        // Single frame with defaults.
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_load_c1", 32'(load_en), 1);
        for (int cy = 2; cy <= 21; cy++) begin
            tick();
            chk("single_enable", 32'(enable), 32'(stage_en[(cy - 2) / 5]));
            chk("single_sel", 32'(SEL), 32'((cy - 2) / 5));
        end
        tick();
        chk("single_ov_c22", 32'(out_valid), 1);
        chk("single_fcnt_c22", 32'(frame_cnt), 0);
        tick();
        chk("single_fcnt_c23", 32'(frame_cnt), 1);
        chk("single_ov_c23", 32'(out_valid), 0);

        // Backpressure, with in_valid held high through HOLD.
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (21) tick();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_ov", 32'(out_valid), 1);
            chk("bp_enable", 32'(enable), 0);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_fcnt", 32'(frame_cnt), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_fcnt_after", 32'(frame_cnt), 2);
        chk("bp_in_ready_after", 32'(in_ready), 1);
        chk("bp_no_early_load", 32'(load_en), 0);
        tick();
        chk("b2b_load_next", 32'(load_en), 1);
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Abort at k=2, c=3 (cycle 15 of the frame).
        repeat (14) tick();
        chk("abort_pre_enable", 32'(enable), 4);
        chk("abort_pre_sel", 32'(SEL), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_enable", 32'(enable), 0);
        chk("abort_fcnt", 32'(frame_cnt), 2);

        // New frame after abort, then reset during HOLD with out_ready.
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_abort_load", 32'(load_en), 1);
        repeat (21) tick();
        chk("rst_hold_ov_pre", 32'(out_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_hold_fcnt", 32'(frame_cnt), 0);
        chk("rst_hold_ov", 32'(out_valid), 0);
        chk("rst_hold_in_ready", 32'(in_ready), 1);

        // Abort beats in_valid in IDLE.
        in_valid = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle_load", 32'(load_en), 0);
        chk("abort_idle_in_ready", 32'(in_ready), 1);

        // Abort beats out_ready in HOLD.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (21) tick();
        chk("abort_hold_ov_pre", 32'(out_valid), 1);
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort_hold_fcnt", 32'(frame_cnt), 0);
        chk("abort_hold_busy", 32'(busy), 0);

        // 256 back-to-back frames: 23-cycle spacing and counter wrap.
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int n = 1; n <= 256 * 23; n++) begin
            tick();
            chk("b2b_load_spacing", 32'(load_en), 32'(n % 23 == 1));
            if (n == 128 * 23) chk("b2b_fcnt_mid", 32'(frame_cnt), 128);
        end
        chk("b2b_fcnt_wrap", 32'(frame_cnt), 0);
        chk("b2b_in_ready_end", 32'(in_ready), 1);
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            abort     = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        abort = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
